pingpong_transbuf: RTL and testbench
====================================

PINGPONG_TRANSBUF -- requirements
Module: pingpong_transbuf

Interface
REQ-001 SHALL provide parameter DW, default 12, as the sample width in bits.
REQ-002 SHALL provide clk, input, 1, as the clock; all state changes on the rising edge.
REQ-003 SHALL provide rst, input, 1, as the reset: asynchronous, active-high.
REQ-004 SHALL provide in_valid, input, 1, meaning the row vector on in_row0..7 is valid.
REQ-005 SHALL provide in_ready, output, 1, meaning a row vector is accepted this cycle if in_valid=1.
REQ-006 SHALL provide in_row0..in_row7, input, DW each, as one 8-sample row; in_rowk is column k.
REQ-007 SHALL provide out_valid, output, 1, meaning out_col0..7 carries a valid column vector.
REQ-008 SHALL provide out_ready, input, 1, meaning the consumer takes the column this cycle if out_valid=1.
REQ-009 SHALL provide out_col0..out_col7, output, DW each, as one 8-sample column; out_colk is row k.
REQ-010 SHALL provide out_last, output, 1, asserted with the 8th (col 7) column of each block.
REQ-011 SHALL provide level, output, 2, as the count of full banks (0..2).

Function
REQ-012 SHALL hold two banks (0, 1), each an 8x8 array of DW-bit registers, indexed [row][col].
REQ-013 SHALL keep per-bank full flags, write bank pointer wbank, row counter wrow (0..7), read bank pointer rbank, and column counter rcol (0..7).
REQ-014 SHALL drive in_ready = ~full[wbank], from registered state only, with no same-cycle bypass from the read side.
REQ-015 SHALL, on in_valid & in_ready, write in_rowk to bank[wbank][wrow][k] for k=0..7 and increment wrow.
REQ-016 SHALL, on the accept with wrow=7, set full[wbank], toggle wbank, and clear wrow to 0.
REQ-017 SHALL drive out_valid = full[rbank] and out_colk = bank[rbank][k][rcol], read combinationally from the registered storage.
REQ-018 SHALL assert out_last = out_valid & (rcol=7).
REQ-019 SHALL, on out_valid & out_ready, increment rcol; at rcol=7 it SHALL clear full[rbank], toggle rbank, and clear rcol to 0.
REQ-020 SHALL hold out_col0..7 and out_last stable while out_valid=1 and out_ready=0.
REQ-021 SHALL present the first column of a block in the cycle after the edge that accepted its 8th row (latency 1 cycle).
REQ-022 SHALL allow a write into one bank and a read from the other in the same cycle, independently.
REQ-023 SHALL, when a bank is freed and the writer is stalled on it in the same cycle, keep in_ready=0 for that cycle and raise it on the next cycle.
REQ-024 SHALL, when a bank fills and the read side is idle in the same cycle, raise out_valid on the next cycle.
REQ-025 SHALL sustain one row in and one column out per cycle in steady state with no bubbles, with both banks alternating.
REQ-026 SHALL drive level = full[0] + full[1], updated in the same cycle as the full flags.
REQ-027 SHALL ignore in_row data when in_valid=0 or in_ready=0, and ignore out_ready when out_valid=0.
REQ-028 SHALL wrap wbank, rbank, wrow, and rcol modulo their range without an error state.

Reset
REQ-029 SHALL, on rst=1 regardless of clk and mid-block, clear all bank registers, full flags, wbank, rbank, wrow, and rcol to 0.
REQ-030 SHALL, during and after reset, drive out_valid=0, out_last=0, out_col0..7=0, level=0, and in_ready=1.
REQ-031 SHALL discard any partially written or partially read block on reset.

Verification
REQ-032 SHALL verify single block: rows r=0..7 with in_rowk=16*r+k, out_ready=1 -> out_valid rises 1 cycle after the last row; column c gives out_colk=16*k+c; out_last only on c=7.
REQ-033 SHALL verify back-pressure: 3 blocks sent back-to-back with out_ready=0 -> in_ready falls after 16 rows; level=2; no data loss once out_ready=1; blocks come out in order.
REQ-034 SHALL verify streaming: continuous in_valid=1 and out_ready=1 for 5 blocks -> in_ready constantly 1 after the first fill; 40 columns out with no gaps; data transposed correctly.
REQ-035 SHALL verify an output stall: out_ready toggled 1,0,0,1 during column 3 -> out_col values held and rcol does not advance during the stall.
REQ-036 SHALL verify reset mid-operation: rst pulsed after 5 rows of block 1 while block 0 is at column 2 -> all outputs at reset values; the next full block transposes correctly from bank 0.
REQ-037 SHALL verify simultaneous free/fill: bank 0 read completes on the same edge bank 1's 8th row is written -> level goes 2->1 correctly, and in_ready returns to 1 the following cycle.

Source files
------------

// File: rtl/pingpong_transbuf.sv
// Double-buffered 8x8 transpose: 8 rows are written into one bank while 8 columns are read from the other.
// Latency: the first column of a block appears the cycle after its 8th row is accepted.
// Backpressure: in_ready drops only while the write bank is still full; out_ready=0 holds the current column.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     row handshake; in_row0..7 carry columns 0..7 of one row
//   out_valid/out_ready   column handshake; out_col0..7 carry rows 0..7 of one column
//   out_last              high with column 7 of each block
//   level                 number of full banks (0..2)
module pingpong_transbuf #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_row0,
  input  logic [DW-1:0] in_row1,
  input  logic [DW-1:0] in_row2,
  input  logic [DW-1:0] in_row3,
  input  logic [DW-1:0] in_row4,
  input  logic [DW-1:0] in_row5,
  input  logic [DW-1:0] in_row6,
  input  logic [DW-1:0] in_row7,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_col0,
  output logic [DW-1:0] out_col1,
  output logic [DW-1:0] out_col2,
  output logic [DW-1:0] out_col3,
  output logic [DW-1:0] out_col4,
  output logic [DW-1:0] out_col5,
  output logic [DW-1:0] out_col6,
  output logic [DW-1:0] out_col7,
  output logic          out_last,
  output logic [1:0]    level
);

  // Storage indexed [bank][row][col].
  logic [DW-1:0] mem [2][8][8];
  logic [1:0]    full;
  logic          wbank;
  logic          rbank;
  logic [2:0]    wrow;
  logic [2:0]    rcol;

  logic [DW-1:0] row_in  [8];
  logic [DW-1:0] col_out [8];
  logic          wr_fire;
  logic          rd_fire;

  assign row_in[0] = in_row0;
  assign row_in[1] = in_row1;
  assign row_in[2] = in_row2;
  assign row_in[3] = in_row3;
  assign row_in[4] = in_row4;
  assign row_in[5] = in_row5;
  assign row_in[6] = in_row6;
  assign row_in[7] = in_row7;

  // Both handshakes look only at registered flags: a bank freed this cycle
  // becomes writable on the next one, so there is no read-to-write comb path.
  assign in_ready  = ~full[wbank];
  assign out_valid = full[rbank];
  assign out_last  = out_valid & (rcol == 3'd7);
  assign level     = {1'b0, full[0]} + {1'b0, full[1]};

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      col_out[k] = mem[rbank][k][rcol];
    end
  end

  assign out_col0 = col_out[0];
  assign out_col1 = col_out[1];
  assign out_col2 = col_out[2];
  assign out_col3 = col_out[3];
  assign out_col4 = col_out[4];
  assign out_col5 = col_out[5];
  assign out_col6 = col_out[6];
  assign out_col7 = col_out[7];

  // A write only targets a non-full bank and a read only a full one, so the
  // two sides never touch the same full flag in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 8; c++) begin
            mem[b][r][c] <= '0;
          end
        end
      end
      full  <= 2'b00;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wrow  <= 3'd0;
      rcol  <= 3'd0;
    end else begin
      if (wr_fire) begin
        for (int k = 0; k < 8; k++) begin
          mem[wbank][wrow][k] <= row_in[k];
        end
        if (wrow == 3'd7) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
          wrow        <= 3'd0;
        end else begin
          wrow <= wrow + 3'd1;
        end
      end
      if (rd_fire) begin
        if (rcol == 3'd7) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
          rcol        <= 3'd0;
        end else begin
          rcol <= rcol + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pingpong_transbuf.sv
module tb_pingpong_transbuf;

  localparam int DW = 12;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [1:0]    level;
  logic [DW-1:0] row_d [8];
  logic [DW-1:0] col_q [8];

  pingpong_transbuf #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row0(row_d[0]), .in_row1(row_d[1]), .in_row2(row_d[2]), .in_row3(row_d[3]),
    .in_row4(row_d[4]), .in_row5(row_d[5]), .in_row6(row_d[6]), .in_row7(row_d[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_col0(col_q[0]), .out_col1(col_q[1]), .out_col2(col_q[2]), .out_col3(col_q[3]),
    .out_col4(col_q[4]), .out_col5(col_q[5]), .out_col6(col_q[6]), .out_col7(col_q[7]),
    .out_last(out_last), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: a 2-deep FIFO of whole blocks ----------------
  typedef logic [63:0][DW-1:0] blk_t;   // element r*8+c
  blk_t mq[$];                          // completed blocks awaiting readout
  blk_t part;                           // block being assembled
  int   prow;                           // rows in part
  int   mcol;                           // next column of mq[0] to emit
  int   m_rows_acc;
  int   m_blocks_out;
  logic [DW-1:0] cur_row [8];

  // DUT values sampled at the last check point
  logic          s_in_ready, s_out_valid, s_out_last;
  logic [1:0]    s_level;
  logic [DW-1:0] s_col [8];

  task automatic new_row();
    for (int k = 0; k < 8; k++) cur_row[k] = DW'($urandom);
  endtask

  task automatic model_clear();
    mq.delete();
    prow = 0;
    mcol = 0;
  endtask

  task automatic check_vs_model();
    logic exp_v;
    exp_v = (mq.size() > 0);
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("level", 32'(level), 32'(mq.size()));
    chk("out_last", 32'(out_last), 32'(exp_v && mcol == 7));
    if (exp_v) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("out_col%0d", k), 32'(col_q[k]), 32'(mq[0][k*8+mcol]));
    end
  endtask

  // One clock cycle driven and checked against the model.
  task automatic cycle(input logic v, input logic r);
    logic wf, rf;
    in_valid  = v;
    out_ready = r;
    for (int k = 0; k < 8; k++) row_d[k] = cur_row[k];
    #2;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_last  = out_last;
    s_level     = level;
    for (int k = 0; k < 8; k++) s_col[k] = col_q[k];
    check_vs_model();
    wf = v && (mq.size() < 2);
    rf = r && (mq.size() > 0);
    @(posedge clk);
    if (rf) begin
      mcol++;
      if (mcol == 8) begin
        void'(mq.pop_front());
        mcol = 0;
        m_blocks_out++;
      end
    end
    if (wf) begin
      for (int k = 0; k < 8; k++) part[prow*8+k] = cur_row[k];
      prow++;
      m_rows_acc++;
      if (prow == 8) begin
        mq.push_back(part);
        prow = 0;
      end
      new_row();
    end
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) chk($sformatf("rst out_col%0d", k), 32'(col_q[k]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    m_rows_acc   = 0;
    m_blocks_out = 0;
  endtask

  // ---------------- table-driven single-block vectors ----------------
  typedef struct {
    logic                v;
    logic                r;
    logic [7:0][DW-1:0]  row;
    logic                e_in_ready;
    logic                e_out_valid;
    logic                e_out_last;
    logic [1:0]          e_level;
    logic [7:0][DW-1:0]  e_col;
  } vec_t;

  vec_t tv [17];

  initial begin
    int stall_n, low_n, cols_n;
    logic [DW-1:0] hold [8];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) row_d[k] = '0;
    new_row();
    model_clear();
    m_rows_acc = 0; m_blocks_out = 0;

    // rows 0..7 with in_rowk = 16r+k, then 8 columns with out_colk = 16k+c
    for (int i = 0; i < 17; i++) begin
      tv[i].v = (i < 8);
      tv[i].r = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tv[i].row[k]   = (i < 8) ? DW'(16*i + k) : '0;
        tv[i].e_col[k] = (i >= 8 && i < 16) ? DW'(16*k + (i-8)) : '0;
      end
      tv[i].e_in_ready  = 1'b1;
      tv[i].e_out_valid = (i >= 8 && i < 16);
      tv[i].e_out_last  = (i == 15);
      tv[i].e_level     = (i >= 8 && i < 16) ? 2'd1 : 2'd0;
    end

    #3;
    do_reset();

    for (int i = 0; i < 17; i++) begin
      in_valid  = tv[i].v;
      out_ready = tv[i].r;
      for (int k = 0; k < 8; k++) row_d[k] = tv[i].row[k];
      #2;
      chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tv[i].e_in_ready));
      chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tv[i].e_out_valid));
      chk($sformatf("tbl%0d out_last", i), 32'(out_last), 32'(tv[i].e_out_last));
      chk($sformatf("tbl%0d level", i), 32'(level), 32'(tv[i].e_level));
      if (tv[i].e_out_valid) begin
        for (int k = 0; k < 8; k++)
          chk($sformatf("tbl%0d col%0d", i, k), 32'(col_q[k]), 32'(tv[i].e_col[k]));
      end
      @(posedge clk);
      #1;
    end

    // ---------------- back-pressure: 3 blocks, consumer stalled ----------------
    do_reset();
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0);
    chk("bp rows accepted", 32'(m_rows_acc), 32'd16);
    chk("bp level", 32'(s_level), 32'd2);
    chk("bp in_ready", 32'(s_in_ready), 32'd0);
    for (int i = 0; i < 80 && (m_blocks_out < 3); i++) cycle(m_rows_acc < 24, 1'b1);
    chk("bp blocks out", 32'(m_blocks_out), 32'd3);

    // ---------------- streaming: 5 blocks, both sides always ready ----------------
    do_reset();
    low_n = 0; cols_n = 0; stall_n = 0;
    for (int i = 0; i < 48; i++) begin
      cycle(m_rows_acc < 40, 1'b1);
      if (i < 40 && !s_in_ready) low_n++;
      if (i >= 8 && !s_out_valid) stall_n++;
      if (s_out_valid) cols_n++;
    end
    chk("stream in_ready low cycles", 32'(low_n), 32'd0);
    chk("stream output gaps", 32'(stall_n), 32'd0);
    chk("stream columns", 32'(cols_n), 32'd40);
    chk("stream blocks", 32'(m_blocks_out), 32'd5);

    // ---------------- output stall during column 3 ----------------
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);   // column 2 taken
    cycle(1'b0, 1'b0);   // column 3 held
    for (int k = 0; k < 8; k++) hold[k] = s_col[k];
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) chk($sformatf("stall hold col%0d", k), 32'(s_col[k]), 32'(hold[k]));
    chk("stall out_last", 32'(s_out_last), 32'd0);
    cycle(1'b0, 1'b1);   // column 3 taken
    for (int k = 0; k < 8; k++) chk($sformatf("stall resume col%0d", k), 32'(s_col[k]), 32'(hold[k]));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
    chk("stall blocks", 32'(m_blocks_out), 32'd1);

    // ---------------- reset mid-operation ----------------
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);   // block1 at 5 rows, block0 at col 2
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1);
    chk("post-reset blocks", 32'(m_blocks_out), 32'd1);
    chk("post-reset level", 32'(s_level), 32'd0);

    // ---------------- simultaneous free/fill ----------------
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);   // col 7 of bank0 and row 7 of bank1 on the same edge
    chk("sim pre level", 32'(s_level), 32'd1);
    chk("sim last", 32'(s_out_last), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);   // fill the other bank too
    chk("sim full level", 32'(level), 32'd2);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);   // frees a bank while the writer is stalled
    chk("sim free in_ready", 32'(s_in_ready), 32'd0);
    chk("sim free level", 32'(s_level), 32'd2);
    cycle(1'b1, 1'b1);
    chk("sim next in_ready", 32'(s_in_ready), 32'd1);
    chk("sim next level", 32'(s_level), 32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);

    // ---------------- randomized traffic ----------------
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
